exception_ctrl: RTL and testbench

EXCEPTION_CTRL -- requirements
Module: exception_ctrl

---
 rtl/exception_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_exception_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exception_ctrl.sv
// -----------------------------------------------------------------------------
// exception_ctrl
//   Precise-exception and interrupt controller sitting at the MEM stage of a
//   MIPS-style pipeline. It resolves the highest-priority event of the MEM
//   instruction (or a pending interrupt), emits a one-cycle registered CP0
//   update plus pipeline flush, and then requests a fetch redirect that is held
//   until the fetch unit acknowledges it.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   hw_int             asynchronous level-sensitive hardware interrupt lines
//   valid_m, stall_m   MEM-stage instruction valid / stalled
//   except_m           per-instruction flags [7]AdEL-fetch [6]Sys [5]Bp
//                      [4]ERET [3]RI [2]Ov
//   adel_m, ades_m     data load / store address error
//   pc_m, addr_m       MEM PC and data address
//   cp0_epc            current EPC (ERET return target)
//   bd_m               MEM instruction is in a branch delay slot
//   cp0_status/cause   IM/EXL/IE and software IP bits
//   exc_*              registered CP0 update, exc_valid is a 1-cycle pulse
//   flush              pipeline flush, coincident with exc_valid
//   redirect_valid/pc  fetch redirect request, held until redirect_ack
//   int_pending        synchronised hw_int (feeds cause[15:10])
// -----------------------------------------------------------------------------
module exception_ctrl #(
  parameter int          NUM_HW_INT  = 6,
  parameter logic [31:0] EXC_VEC     = 32'hBFC0_0380,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_HW_INT-1:0] hw_int,
  input  logic                  valid_m,
  input  logic                  stall_m,
  input  logic [7:0]            except_m,
  input  logic                  adel_m,
  input  logic                  ades_m,
  input  logic [31:0]           pc_m,
  input  logic [31:0]           addr_m,
  input  logic [31:0]           cp0_epc,
  input  logic                  bd_m,
  input  logic [31:0]           cp0_status,
  input  logic [31:0]           cp0_cause,
  output logic                  exc_valid,
  output logic [4:0]            exc_code,
  output logic [31:0]           exc_epc,
  output logic [31:0]           exc_badvaddr,
  output logic                  exc_bd,
  output logic                  exc_is_eret,
  output logic                  flush,
  output logic                  redirect_valid,
  output logic [31:0]           redirect_pc,
  input  logic                  redirect_ack,
  output logic [NUM_HW_INT-1:0] int_pending
);

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    REDIRECT
  } state_t;

  state_t state_q, state_d;

  logic [NUM_HW_INT-1:0] sync_q [SYNC_STAGES];

  logic        exc_valid_q,      exc_valid_d;
  logic        flush_q,          flush_d;
  logic [4:0]  exc_code_q,       exc_code_d;
  logic [31:0] exc_epc_q,        exc_epc_d;
  logic [31:0] exc_badvaddr_q,   exc_badvaddr_d;
  logic        exc_bd_q,         exc_bd_d;
  logic        exc_is_eret_q,    exc_is_eret_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q,    redirect_pc_d;

  logic [5:0]  hw_ip;
  logic [7:0]  ip;
  logic        irq;
  logic        take;
  logic        win;
  logic [4:0]  win_code;
  logic [31:0] win_badvaddr;
  logic        win_eret;
  logic [31:0] epc_norm;

  // Bits of the CP0 words and flag vector that this block does not decode.
  logic unused_bits;
  assign unused_bits = ^{except_m[1:0], cp0_status[31:16], cp0_status[7:2],
                         cp0_cause[31:10], cp0_cause[7:0]};

  // hw_int crosses into the clock domain through a plain flop chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= hw_int;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign int_pending = sync_q[SYNC_STAGES-1];

  // Interrupt request: hardware lines occupy IP[7:2], software IP[1:0].
  always_comb begin
    hw_ip                   = '0;
    hw_ip[NUM_HW_INT-1:0]   = int_pending;
    ip                      = {hw_ip, cp0_cause[9:8]};
    irq                     = (|(ip & cp0_status[15:8])) & cp0_status[0] & ~cp0_status[1];
  end

  assign take     = (state_q == IDLE) && valid_m && !stall_m;
  assign epc_norm = bd_m ? (pc_m - 32'd4) : pc_m;

  // Fixed-priority resolution of the MEM-stage candidate.
  always_comb begin
    win          = 1'b1;
    win_code     = 5'h00;
    win_badvaddr = 32'h0;
    win_eret     = 1'b0;
    if (irq) begin
      win_code = 5'h00;
    end else if (except_m[7]) begin
      win_code     = 5'h04;
      win_badvaddr = pc_m;
    end else if (except_m[3]) begin
      win_code = 5'h0a;
    end else if (except_m[2]) begin
      win_code = 5'h0c;
    end else if (except_m[6]) begin
      win_code = 5'h08;
    end else if (except_m[5]) begin
      win_code = 5'h09;
    end else if (adel_m) begin
      win_code     = 5'h04;
      win_badvaddr = addr_m;
    end else if (ades_m) begin
      win_code     = 5'h05;
      win_badvaddr = addr_m;
    end else if (except_m[4]) begin
      win_eret = 1'b1;
    end else begin
      win = 1'b0;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d          = state_q;
    exc_valid_d      = 1'b0;
    flush_d          = 1'b0;
    exc_code_d       = exc_code_q;
    exc_epc_d        = exc_epc_q;
    exc_badvaddr_d   = exc_badvaddr_q;
    exc_bd_d         = exc_bd_q;
    exc_is_eret_d    = exc_is_eret_q;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    unique case (state_q)
      IDLE: begin
        if (take && win) begin
          state_d        = FLUSH;
          exc_valid_d    = 1'b1;
          flush_d        = 1'b1;
          exc_code_d     = win_code;
          exc_badvaddr_d = win_badvaddr;
          exc_bd_d       = bd_m;
          exc_is_eret_d  = win_eret;
          // ERET target is captured here so later EPC writes cannot move it.
          exc_epc_d      = win_eret ? cp0_epc : epc_norm;
          redirect_pc_d  = win_eret ? cp0_epc : EXC_VEC;
        end
      end
      FLUSH: begin
        state_d          = REDIRECT;
        redirect_valid_d = 1'b1;
      end
      REDIRECT: begin
        if (redirect_ack) begin
          state_d          = IDLE;
          redirect_valid_d = 1'b0;
        end
      end
      default: begin
        state_d          = IDLE;
        redirect_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      exc_valid_q      <= 1'b0;
      flush_q          <= 1'b0;
      exc_code_q       <= 5'h00;
      exc_epc_q        <= 32'h0;
      exc_badvaddr_q   <= 32'h0;
      exc_bd_q         <= 1'b0;
      exc_is_eret_q    <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'h0;
    end else begin
      state_q          <= state_d;
      exc_valid_q      <= exc_valid_d;
      flush_q          <= flush_d;
      exc_code_q       <= exc_code_d;
      exc_epc_q        <= exc_epc_d;
      exc_badvaddr_q   <= exc_badvaddr_d;
      exc_bd_q         <= exc_bd_d;
      exc_is_eret_q    <= exc_is_eret_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign exc_valid      = exc_valid_q;
  assign flush          = flush_q;
  assign exc_code       = exc_code_q;
  assign exc_epc        = exc_epc_q;
  assign exc_badvaddr   = exc_badvaddr_q;
  assign exc_bd         = exc_bd_q;
  assign exc_is_eret    = exc_is_eret_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_exception_ctrl.sv
// -----------------------------------------------------------------------------
// tb_exception_ctrl
//   Directed scenarios followed by randomized traffic, all compared every cycle
//   against a transaction-level reference model kept in this file.
// -----------------------------------------------------------------------------
module tb_exception_ctrl;

  localparam int          NHW = 6;
  localparam logic [31:0] VEC = 32'hBFC0_0380;
  localparam int          SS  = 2;

  logic            clk;
  logic            rst;
  logic [NHW-1:0]  hw_int;
  logic            valid_m, stall_m;
  logic [7:0]      except_m;
  logic            adel_m, ades_m;
  logic [31:0]     pc_m, addr_m, cp0_epc;
  logic            bd_m;
  logic [31:0]     cp0_status, cp0_cause;
  logic            redirect_ack;

  logic            exc_valid;
  logic [4:0]      exc_code;
  logic [31:0]     exc_epc, exc_badvaddr;
  logic            exc_bd, exc_is_eret, flush;
  logic            redirect_valid;
  logic [31:0]     redirect_pc;
  logic [NHW-1:0]  int_pending;

  exception_ctrl #(
    .NUM_HW_INT (NHW),
    .EXC_VEC    (VEC),
    .SYNC_STAGES(SS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .hw_int        (hw_int),
    .valid_m       (valid_m),
    .stall_m       (stall_m),
    .except_m      (except_m),
    .adel_m        (adel_m),
    .ades_m        (ades_m),
    .pc_m          (pc_m),
    .addr_m        (addr_m),
    .cp0_epc       (cp0_epc),
    .bd_m          (bd_m),
    .cp0_status    (cp0_status),
    .cp0_cause     (cp0_cause),
    .exc_valid     (exc_valid),
    .exc_code      (exc_code),
    .exc_epc       (exc_epc),
    .exc_badvaddr  (exc_badvaddr),
    .exc_bd        (exc_bd),
    .exc_is_eret   (exc_is_eret),
    .flush         (flush),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .redirect_ack  (redirect_ack),
    .int_pending   (int_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: phase 0 = accepting, 1 = just raised an exception,
  // 2 = waiting for the fetch unit to accept the redirect.
  int          m_phase;
  logic [5:0]  m_hist[$];
  logic        e_valid, e_flush, e_bd, e_eret, e_rv;
  logic [4:0]  e_code;
  logic [31:0] e_epc, e_bva, e_rpc, m_target;
  logic        rpc_known;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Synchronised interrupt value: the hw_int sample taken SS edges ago.
  function automatic logic [5:0] m_pending();
    if (m_hist.size() >= SS) return m_hist[m_hist.size() - SS];
    return 6'h0;
  endfunction

  task automatic model_step();
    logic [5:0]  pend;
    logic [7:0]  ipm;
    logic        irq;
    logic [8:0]  req;
    int          codes [9];
    int          w;
    codes = '{0, 4, 10, 12, 8, 9, 4, 5, 0};
    if (rst) begin
      m_hist.delete();
      m_phase = 0;
      e_valid = 0; e_flush = 0; e_bd = 0; e_eret = 0; e_rv = 0;
      e_code = 0; e_epc = 0; e_bva = 0; e_rpc = 0; rpc_known = 1;
    end else begin
      pend    = m_pending();
      e_valid = 0;
      e_flush = 0;
      if (m_phase == 0) begin
        if (valid_m && !stall_m) begin
          ipm = {pend, cp0_cause[9:8]};
          irq = ((ipm & cp0_status[15:8]) != 8'h0) && cp0_status[0] && !cp0_status[1];
          // Candidate list, highest priority at index 0.
          req = {except_m[4], ades_m, adel_m, except_m[5], except_m[6],
                 except_m[2], except_m[3], except_m[7], irq};
          w = -1;
          for (int i = 8; i >= 0; i--) if (req[i]) w = i;
          if (w >= 0) begin
            e_valid   = 1;
            e_flush   = 1;
            e_code    = 5'(codes[w]);
            e_bd      = bd_m;
            e_eret    = (w == 8);
            e_bva     = (w == 1) ? pc_m : ((w == 6 || w == 7) ? addr_m : 32'h0);
            e_epc     = (w == 8) ? cp0_epc : (bd_m ? pc_m - 32'd4 : pc_m);
            m_target  = (w == 8) ? cp0_epc : VEC;
            rpc_known = 0;
            m_phase   = 1;
          end
        end
      end else if (m_phase == 1) begin
        m_phase   = 2;
        e_rv      = 1;
        e_rpc     = m_target;
        rpc_known = 1;
      end else if (redirect_ack) begin
        m_phase = 0;
        e_rv    = 0;
      end
      m_hist.push_back(6'(hw_int));
      if (m_hist.size() > 8) void'(m_hist.pop_front());
    end
  endtask

  task automatic compare_all();
    check("exc_valid",      32'(exc_valid),      32'(e_valid));
    check("flush",          32'(flush),          32'(e_flush));
    check("exc_code",       32'(exc_code),       32'(e_code));
    check("exc_epc",        exc_epc,             e_epc);
    check("exc_badvaddr",   exc_badvaddr,        e_bva);
    check("exc_bd",         32'(exc_bd),         32'(e_bd));
    check("exc_is_eret",    32'(exc_is_eret),    32'(e_eret));
    check("redirect_valid", 32'(redirect_valid), 32'(e_rv));
    check("int_pending",    32'(int_pending),    32'(m_pending()));
    if (rpc_known) check("redirect_pc", redirect_pc, e_rpc);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic clear_inputs();
    valid_m = 0; stall_m = 0; except_m = 8'h0; adel_m = 0; ades_m = 0;
    redirect_ack = 0; bd_m = 0;
  endtask

  // Called while the controller is in its flush cycle: walk through redirect.
  task automatic finish_redirect();
    valid_m = 0;
    tick();
    redirect_ack = 1;
    tick();
    redirect_ack = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; hw_int = '0; cp0_status = 32'h0; cp0_cause = 32'h0;
    pc_m = 32'h0; addr_m = 32'h0; cp0_epc = 32'h0;
    clear_inputs();

    // Reset state
    tick();
    tick();
    check("rst.exc_valid", 32'(exc_valid), 32'd0);
    check("rst.redirect_valid", 32'(redirect_valid), 32'd0);
    check("rst.redirect_pc", redirect_pc, 32'h0);
    rst = 0;
    tick();

    // Overflow in a delay slot
    valid_m = 1; except_m = 8'h04; pc_m = 32'h8000_0010; bd_m = 1;
    tick();
    check("ov.valid", 32'(exc_valid), 32'd1);
    check("ov.flush", 32'(flush), 32'd1);
    check("ov.code", 32'(exc_code), 32'h0c);
    check("ov.epc", exc_epc, 32'h8000_000C);
    check("ov.bd", 32'(exc_bd), 32'd1);
    clear_inputs();
    tick();
    check("ov.redirect_valid", 32'(redirect_valid), 32'd1);
    check("ov.redirect_pc", redirect_pc, 32'hBFC0_0380);
    redirect_ack = 1;
    tick();
    check("ov.ack", 32'(redirect_valid), 32'd0);
    redirect_ack = 0;

    // Interrupt latency through the synchroniser, beating Sys on the same cycle
    cp0_status = 32'h0000_0401;
    valid_m = 1; except_m = 8'h40; pc_m = 32'h8000_0040; hw_int = 6'b000001;
    for (int k = 1; k <= SS + 1; k++) begin
      stall_m = (k <= SS);
      tick();
      check("irq.timing", 32'(exc_valid), 32'(k == SS + 1));
    end
    check("irq.code", 32'(exc_code), 32'h00);
    check("irq.eret", 32'(exc_is_eret), 32'd0);
    except_m = 8'h0;
    tick();
    check("irq.redirect", 32'(redirect_valid), 32'd1);
    redirect_ack = 1;
    tick();
    redirect_ack = 0;
    tick();
    check("irq.retake", 32'(exc_valid), 32'd1);
    check("irq.retake_code", 32'(exc_code), 32'h00);
    hw_int = '0;
    cp0_status = 32'h0;
    finish_redirect();

    // RI outranks AdES; AdES alone reports the data address
    valid_m = 1; ades_m = 1; addr_m = 32'h1000_0002; except_m = 8'h08;
    tick();
    check("ri.code", 32'(exc_code), 32'h0a);
    check("ri.badvaddr", exc_badvaddr, 32'h0);
    clear_inputs();
    finish_redirect();
    valid_m = 1; ades_m = 1; addr_m = 32'h1000_0002;
    tick();
    check("ades.code", 32'(exc_code), 32'h05);
    check("ades.badvaddr", exc_badvaddr, 32'h1000_0002);
    clear_inputs();
    finish_redirect();

    // ERET with a slow fetch acknowledge
    valid_m = 1; except_m = 8'h10; cp0_epc = 32'h8000_0100; pc_m = 32'h8000_0200;
    tick();
    check("eret.valid", 32'(exc_valid), 32'd1);
    check("eret.flag", 32'(exc_is_eret), 32'd1);
    check("eret.code", 32'(exc_code), 32'h00);
    check("eret.epc", exc_epc, 32'h8000_0100);
    cp0_epc = 32'h1234_5678; except_m = 8'h40;
    tick();
    check("eret.redirect_pc", redirect_pc, 32'h8000_0100);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("eret.hold_valid", 32'(redirect_valid), 32'd1);
      check("eret.hold_pc", redirect_pc, 32'h8000_0100);
      check("eret.ignored", 32'(exc_valid), 32'd0);
    end
    redirect_ack = 1; valid_m = 0; except_m = 8'h0;
    tick();
    check("eret.released", 32'(redirect_valid), 32'd0);
    redirect_ack = 0;

    // Reset during redirect, no take under reset, stall holds off Sys
    valid_m = 1; except_m = 8'h20;
    tick();
    check("bp.code", 32'(exc_code), 32'h09);
    clear_inputs();
    tick();
    check("bp.redirect", 32'(redirect_valid), 32'd1);
    rst = 1; valid_m = 1; except_m = 8'h40;
    tick();
    check("rstr.redirect_valid", 32'(redirect_valid), 32'd0);
    check("rstr.exc_valid", 32'(exc_valid), 32'd0);
    check("rstr.redirect_pc", redirect_pc, 32'h0);
    rst = 0; stall_m = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall.no_exc", 32'(exc_valid), 32'd0);
    end
    stall_m = 0;
    tick();
    check("stall.release", 32'(exc_valid), 32'd1);
    check("stall.code", 32'(exc_code), 32'h08);
    clear_inputs();
    finish_redirect();

    // Randomized traffic against the model
    for (int n = 0; n < 500; n++) begin
      rst      = ($urandom_range(99) == 0);
      valid_m  = ($urandom_range(9) < 7);
      stall_m  = ($urandom_range(9) < 2);
      except_m = 8'h0;
      for (int b = 0; b < 8; b++) if ($urandom_range(7) == 0) except_m[b] = 1'b1;
      adel_m   = ($urandom_range(9) == 0);
      ades_m   = ($urandom_range(9) == 0);
      redirect_ack = ($urandom_range(9) < 4);
      if ($urandom_range(15) == 0) hw_int = NHW'($urandom);
      cp0_status    = $urandom;
      cp0_status[1] = ($urandom_range(3) == 0);
      cp0_cause  = $urandom;
      pc_m       = $urandom;
      addr_m     = $urandom;
      cp0_epc    = $urandom;
      bd_m       = $urandom_range(1) == 1;
      tick();
    end
    rst = 0;
    clear_inputs();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
